// File: rtl/shwr_integral_capture_pkg.sv
// Shared constants, record layout and FSM state type for the shower integral capture block.
// Build option: define SHWR_CAPTURE_TIMESTAMP_EN to carry a 32-bit trigger timestamp in each record.
package shwr_integral_capture_pkg;
  localparam int NCHAN      = 3;
  localparam int ADC_W      = 12;
  localparam int AREA_W     = 19;
  localparam int BL_W       = 14;
  localparam int AREA_BINS  = 256;
  localparam int PIPE_LAT   = 4;
  localparam int DEPTH_LOG2 = 2;
  localparam int TAG_W      = 8;

  localparam int WIN_LAST = AREA_BINS + PIPE_LAT - 1;
  localparam int WIN_W    = $clog2(AREA_BINS + PIPE_LAT);

  // Record layout, LSB first: integrals, peaks, baselines, saturation flags, tag, timestamp.
  localparam int OFF_INT  = 0;
  localparam int OFF_PEAK = OFF_INT + NCHAN * AREA_W;
  localparam int OFF_BL   = OFF_PEAK + NCHAN * ADC_W;
  localparam int OFF_SAT  = OFF_BL + NCHAN * BL_W;
  localparam int OFF_TAG  = OFF_SAT + NCHAN;
  localparam int OFF_TIME = OFF_TAG + TAG_W;
`ifdef SHWR_CAPTURE_TIMESTAMP_EN
  localparam int TIME_W = 32;
`else
  localparam int TIME_W = 0;
`endif
  localparam int REC_W = OFF_TIME + TIME_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INTEG   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;
endpackage

// File: rtl/shwr_integral_capture_if.sv
// Bundle of trigger/data inputs and event readout outputs for shwr_integral_capture.
// Readout handshake: EVT_VALID high means EVT_* show the head event; EVT_ACK && EVT_VALID on a clock pops it.
interface shwr_integral_capture_if;
  import shwr_integral_capture_pkg::*;

  logic                    TRIGGERED;
  logic [NCHAN*AREA_W-1:0] INTEGRAL_IN;
  logic [NCHAN*ADC_W-1:0]  PEAK_IN;
  logic [NCHAN*BL_W-1:0]   BASELINE_IN;
  logic [NCHAN-1:0]        SATURATED_IN;
  logic                    EVT_ACK;

  logic                    EVT_VALID;
  logic [NCHAN*AREA_W-1:0] EVT_INTEGRAL;
  logic [NCHAN*ADC_W-1:0]  EVT_PEAK;
  logic [NCHAN*BL_W-1:0]   EVT_BASELINE;
  logic [NCHAN-1:0]        EVT_SATURATED;
  logic [7:0]              EVT_TAG;
  logic [31:0]             EVT_TIME;
  logic                    FIFO_FULL;
  logic [7:0]              OVF_CNT;
  logic [7:0]              ABORT_CNT;
  state_t                  state;

  modport slave (
    input  TRIGGERED, INTEGRAL_IN, PEAK_IN, BASELINE_IN, SATURATED_IN, EVT_ACK,
    output EVT_VALID, EVT_INTEGRAL, EVT_PEAK, EVT_BASELINE, EVT_SATURATED,
           EVT_TAG, EVT_TIME, FIFO_FULL, OVF_CNT, ABORT_CNT, state
  );

  modport master (
    output TRIGGERED, INTEGRAL_IN, PEAK_IN, BASELINE_IN, SATURATED_IN, EVT_ACK,
    input  EVT_VALID, EVT_INTEGRAL, EVT_PEAK, EVT_BASELINE, EVT_SATURATED,
           EVT_TAG, EVT_TIME, FIFO_FULL, OVF_CNT, ABORT_CNT, state
  );
endinterface

// File: rtl/shwr_capture_fifo.sv
// Generic first-word fall-through FIFO; a pop in the same cycle frees room for a push when full.
module shwr_capture_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full,
  output logic         drop
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                empty, pop_ok, push_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign valid   = ~empty;
  assign dout    = valid ? mem[rd_ptr[DEPTH_LOG2-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end
endmodule

// File: rtl/shwr_integral_capture.sv
// Waits out the shower integration window after a trigger and queues a per-channel snapshot for readout.
// Build option: SHWR_CAPTURE_TIMESTAMP_EN adds a free-running trigger timestamp to each record.
module shwr_integral_capture
  import shwr_integral_capture_pkg::*;
(
  input logic CLK120,
  input logic RESET,
  shwr_integral_capture_if.slave bus
);
  state_t            state_q, state_d;
  logic              trig_q, rising, capture, pop;
  logic [WIN_W-1:0]  win_cnt;
  logic [7:0]        tag_cnt, ovf_cnt, abort_cnt;
  logic              fifo_valid, fifo_full, fifo_drop;
  logic [REC_W-1:0]  rec, head;

  assign rising  = bus.TRIGGERED & ~trig_q;
  assign capture = (state_q == S_CAPTURE);
  assign pop     = bus.EVT_ACK & fifo_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (rising) state_d = S_INTEG;
      S_INTEG:   if (!bus.TRIGGERED) state_d = S_IDLE;
                 else if (win_cnt == WIN_W'(WIN_LAST)) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_HOLDOFF;
      S_HOLDOFF: if (!bus.TRIGGERED) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // trig_q resets high so a trigger already asserted across reset is not seen as an edge.
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      trig_q    <= 1'b1;
      win_cnt   <= '0;
      tag_cnt   <= '0;
      ovf_cnt   <= '0;
      abort_cnt <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= bus.TRIGGERED;
      win_cnt <= (state_q == S_INTEG) ? win_cnt + 1'b1 : '0;
      if (capture) tag_cnt <= tag_cnt + 8'd1;
      if (fifo_drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      if (state_q == S_INTEG && !bus.TRIGGERED && abort_cnt != 8'hFF)
        abort_cnt <= abort_cnt + 8'd1;
    end
  end

`ifdef SHWR_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt, ts_lat;

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      ts_cnt <= '0;
      ts_lat <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (state_q == S_IDLE && rising) ts_lat <= ts_cnt;
    end
  end
`endif

  always_comb begin
    rec = '0;
    rec[OFF_INT  +: NCHAN*AREA_W] = bus.INTEGRAL_IN;
    rec[OFF_PEAK +: NCHAN*ADC_W]  = bus.PEAK_IN;
    rec[OFF_BL   +: NCHAN*BL_W]   = bus.BASELINE_IN;
    rec[OFF_SAT  +: NCHAN]        = bus.SATURATED_IN;
    rec[OFF_TAG  +: TAG_W]        = tag_cnt;
`ifdef SHWR_CAPTURE_TIMESTAMP_EN
    rec[OFF_TIME +: 32]           = ts_lat;
`endif
  end

  shwr_capture_fifo #(
    .W          (REC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (CLK120),
    .rst   (RESET),
    .push  (capture),
    .din   (rec),
    .pop   (pop),
    .dout  (head),
    .valid (fifo_valid),
    .full  (fifo_full),
    .drop  (fifo_drop)
  );

  assign bus.EVT_VALID     = fifo_valid;
  assign bus.EVT_INTEGRAL  = head[OFF_INT  +: NCHAN*AREA_W];
  assign bus.EVT_PEAK      = head[OFF_PEAK +: NCHAN*ADC_W];
  assign bus.EVT_BASELINE  = head[OFF_BL   +: NCHAN*BL_W];
  assign bus.EVT_SATURATED = head[OFF_SAT  +: NCHAN];
  assign bus.EVT_TAG       = head[OFF_TAG  +: TAG_W];
`ifdef SHWR_CAPTURE_TIMESTAMP_EN
  assign bus.EVT_TIME      = head[OFF_TIME +: 32];
`else
  assign bus.EVT_TIME      = '0;
`endif
  assign bus.FIFO_FULL     = fifo_full;
  assign bus.OVF_CNT       = ovf_cnt;
  assign bus.ABORT_CNT     = abort_cnt;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_shwr_integral_capture.sv
// Directed bench for shwr_integral_capture: expected records queued at trigger time, checked on each ack.
// Honours SHWR_CAPTURE_TIMESTAMP_EN for the expected EVT_TIME values.
module tb_shwr_integral_capture;
  import shwr_integral_capture_pkg::*;

  localparam int TB_REC_W = NCHAN * (AREA_W + ADC_W + BL_W + 1) + 8 + 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tb_time;
  int          checks = 0;
  int          errors = 0;
  logic [TB_REC_W-1:0] exp_q[$];
  logic [TB_REC_W-1:0] mon_exp, mon_act;

  shwr_integral_capture_if bus();

  shwr_integral_capture dut (
    .CLK120 (clk),
    .RESET  (rst),
    .bus    (bus)
  );

  // clock / reset-relative time model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tb_time <= 32'd0;
    else     tb_time <= tb_time + 32'd1;
  end

  task automatic check(input string name, input logic [TB_REC_W-1:0] act,
                       input logic [TB_REC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every accepted pop is compared against the queue head
  always @(negedge clk) begin
    if (!rst && bus.EVT_ACK && bus.EVT_VALID) begin
      check("queue_nonempty", TB_REC_W'(exp_q.size() != 0), TB_REC_W'(1));
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {bus.EVT_TIME, bus.EVT_TAG, bus.EVT_SATURATED, bus.EVT_BASELINE,
                   bus.EVT_PEAK, bus.EVT_INTEGRAL};
        check("event_record", mon_act, mon_exp);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    tick();
  endtask

  task automatic set_fields(input int v);
    for (int c = 0; c < NCHAN; c++) begin
      bus.INTEGRAL_IN[c*AREA_W +: AREA_W] = AREA_W'(32'h1A5A5 + v * 4099 + c * 257);
      bus.PEAK_IN[c*ADC_W +: ADC_W]       = ADC_W'(32'h3C1 + v * 97 + c * 13);
      bus.BASELINE_IN[c*BL_W +: BL_W]     = BL_W'(32'h0C8 + v * 31 + c * 7);
    end
    bus.SATURATED_IN = NCHAN'(v * 5 + 1);
  endtask

  function automatic logic [TB_REC_W-1:0] make_exp(input logic [7:0] tag);
    logic [31:0] t;
`ifdef SHWR_CAPTURE_TIMESTAMP_EN
    t = tb_time;
`else
    t = 32'd0;
`endif
    return {t, tag, bus.SATURATED_IN, bus.BASELINE_IN, bus.PEAK_IN, bus.INTEGRAL_IN};
  endfunction

  // One trigger held ~300 clocks. lat = clocks from the edge that registers the rise to CAPTURE.
  task automatic run_event(input int v, input logic [7:0] tag, input bit stored, input bit ack_cap,
                           output logic vb, output logic va);
    logic [TB_REC_W-1:0] e;
    int n;
    set_fields(v);
    e = make_exp(tag);
    bus.TRIGGERED = 1'b1;
    tick();
    n = 0;
    while (bus.state != S_CAPTURE && n < 400) begin
      tick();
      n++;
    end
    check("capture_latency", TB_REC_W'(n), TB_REC_W'(260));
    vb = bus.EVT_VALID;
    if (ack_cap) bus.EVT_ACK = 1'b1;
    if (stored) exp_q.push_back(e);
    tick();
    bus.EVT_ACK = 1'b0;
    va = bus.EVT_VALID;
    for (int i = n; i < 297; i++) tick();
    check("holdoff_state", TB_REC_W'(bus.state), TB_REC_W'(S_HOLDOFF));
    bus.TRIGGERED = 1'b0;
    tick();
    tick();
    check("idle_after_event", TB_REC_W'(bus.state), TB_REC_W'(S_IDLE));
  endtask

  task automatic drain(input int count);
    int w;
    for (int k = 0; k < count; k++) begin
      w = 0;
      while (!bus.EVT_VALID && w < 20) begin
        tick();
        w++;
      end
      check("drain_valid", TB_REC_W'(bus.EVT_VALID), TB_REC_W'(1));
      bus.EVT_ACK = 1'b1;
      tick();
      bus.EVT_ACK = 1'b0;
    end
  endtask

  initial begin
    logic vb, va;
    int   bad;
    bus.TRIGGERED    = 1'b0;
    bus.EVT_ACK      = 1'b0;
    bus.INTEGRAL_IN  = '0;
    bus.PEAK_IN      = '0;
    bus.BASELINE_IN  = '0;
    bus.SATURATED_IN = '0;
    do_reset();

    // reset state
    check("rst_valid", TB_REC_W'(bus.EVT_VALID), TB_REC_W'(0));
    check("rst_full", TB_REC_W'(bus.FIFO_FULL), TB_REC_W'(0));
    check("rst_ovf", TB_REC_W'(bus.OVF_CNT), TB_REC_W'(0));
    check("rst_abort", TB_REC_W'(bus.ABORT_CNT), TB_REC_W'(0));
    check("rst_state", TB_REC_W'(bus.state), TB_REC_W'(S_IDLE));
    check("rst_fields", {bus.EVT_TIME, bus.EVT_TAG, bus.EVT_SATURATED, bus.EVT_BASELINE,
                         bus.EVT_PEAK, bus.EVT_INTEGRAL}, TB_REC_W'(0));

    // basic capture with hand-set channel 0 values
    set_fields(0);
    bus.INTEGRAL_IN[0 +: AREA_W] = 19'h01234;
    bus.PEAK_IN[0 +: ADC_W]      = 12'h7FF;
    bus.BASELINE_IN[0 +: BL_W]   = 14'h00C8;
    bus.SATURATED_IN             = 3'b010;
    begin
      logic [TB_REC_W-1:0] e;
      int n;
      e = make_exp(8'd0);
      bus.TRIGGERED = 1'b1;
      tick();
      n = 0;
      while (bus.state != S_CAPTURE && n < 400) begin
        tick();
        n++;
      end
      check("basic_latency", TB_REC_W'(n), TB_REC_W'(260));
      check("basic_valid_before", TB_REC_W'(bus.EVT_VALID), TB_REC_W'(0));
      exp_q.push_back(e);
      tick();
      check("basic_valid_after", TB_REC_W'(bus.EVT_VALID), TB_REC_W'(1));
      check("basic_tag", TB_REC_W'(bus.EVT_TAG), TB_REC_W'(0));
      check("basic_int_ch0", TB_REC_W'(bus.EVT_INTEGRAL[0 +: AREA_W]), TB_REC_W'(19'h01234));
      check("basic_peak_ch0", TB_REC_W'(bus.EVT_PEAK[0 +: ADC_W]), TB_REC_W'(12'h7FF));
      check("basic_bl_ch0", TB_REC_W'(bus.EVT_BASELINE[0 +: BL_W]), TB_REC_W'(14'h00C8));
      for (int i = n; i < 297; i++) tick();
      bus.TRIGGERED = 1'b0;
      tick();
      tick();
    end
    drain(1);

    // abort: trigger dropped inside the window
    do_reset();
    set_fields(1);
    bus.TRIGGERED = 1'b1;
    repeat (100) tick();
    bus.TRIGGERED = 1'b0;
    tick();
    tick();
    tick();
    check("abort_cnt", TB_REC_W'(bus.ABORT_CNT), TB_REC_W'(1));
    check("abort_state", TB_REC_W'(bus.state), TB_REC_W'(S_IDLE));
    check("abort_no_event", TB_REC_W'(bus.EVT_VALID), TB_REC_W'(0));
    run_event(2, 8'd0, 1'b1, 1'b0, vb, va);
    drain(1);

    // overflow: five events without acks, fifth is dropped
    do_reset();
    for (int k = 0; k < 4; k++) run_event(10 + k, 8'(k), 1'b1, 1'b0, vb, va);
    check("ovf_full_after_4", TB_REC_W'(bus.FIFO_FULL), TB_REC_W'(1));
    check("ovf_cnt_after_4", TB_REC_W'(bus.OVF_CNT), TB_REC_W'(0));
    run_event(14, 8'd4, 1'b0, 1'b0, vb, va);
    check("ovf_cnt_after_5", TB_REC_W'(bus.OVF_CNT), TB_REC_W'(1));
    check("ovf_head_tag", TB_REC_W'(bus.EVT_TAG), TB_REC_W'(0));
    drain(4);
    check("ovf_empty", TB_REC_W'(bus.EVT_VALID), TB_REC_W'(0));
    run_event(15, 8'd5, 1'b1, 1'b0, vb, va);
    drain(1);

    // full FIFO with ack in the capture cycle: no drop
    for (int k = 0; k < 4; k++) run_event(20 + k, 8'(6 + k), 1'b1, 1'b0, vb, va);
    check("pop_full_before", TB_REC_W'(bus.FIFO_FULL), TB_REC_W'(1));
    run_event(24, 8'd10, 1'b1, 1'b1, vb, va);
    check("pop_ovf_unchanged", TB_REC_W'(bus.OVF_CNT), TB_REC_W'(1));
    check("pop_still_full", TB_REC_W'(bus.FIFO_FULL), TB_REC_W'(1));
    check("pop_head_tag", TB_REC_W'(bus.EVT_TAG), TB_REC_W'(7));
    drain(4);

    // reset mid-window with two events queued
    run_event(30, 8'd11, 1'b1, 1'b0, vb, va);
    run_event(31, 8'd12, 1'b1, 1'b0, vb, va);
    bus.TRIGGERED = 1'b1;
    repeat (101) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", TB_REC_W'(bus.EVT_VALID), TB_REC_W'(0));
    check("mid_rst_ovf", TB_REC_W'(bus.OVF_CNT), TB_REC_W'(0));
    check("mid_rst_abort", TB_REC_W'(bus.ABORT_CNT), TB_REC_W'(0));
    check("mid_rst_state", TB_REC_W'(bus.state), TB_REC_W'(S_IDLE));
    bad = 0;
    repeat (300) begin
      tick();
      if (bus.state != S_IDLE || bus.EVT_VALID) bad++;
    end
    check("held_trigger_ignored", TB_REC_W'(bad), TB_REC_W'(0));
    bus.TRIGGERED = 1'b0;
    tick();
    tick();
    run_event(32, 8'd0, 1'b1, 1'b0, vb, va);
    drain(1);

    // timestamp: rising edge registered when the time counter reads 1000
    do_reset();
    while (tb_time != 32'd1000 && tb_time < 32'd2000) tick();
    run_event(40, 8'd0, 1'b1, 1'b0, vb, va);
`ifdef SHWR_CAPTURE_TIMESTAMP_EN
    check("evt_time", TB_REC_W'(bus.EVT_TIME), TB_REC_W'(1000));
`else
    check("evt_time", TB_REC_W'(bus.EVT_TIME), TB_REC_W'(0));
`endif
    drain(1);

    tick();
    check("scoreboard_empty", TB_REC_W'(exp_q.size()), TB_REC_W'(0));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shwr_integral_capture.md
Name: shwr_integral_capture

Overview:
- Consumer end of the per-channel shower integral/peak/baseline outputs.
- Watches TRIGGERED and waits out the integration window plus pipeline latency. It then snapshots INTEGRAL, PEAK, BASELINE and SATURATED for all channels into a small event FIFO.
- The register/readout side drains the FIFO with a valid/ack handshake.
- Sits between the per-PMT integral instances and the shower readout registers in sde_trigger.

Parameters:
- NCHAN, 3, number of PMT channels captured per event.
- ADC_W, 12, PEAK width per channel.
- AREA_W, 19, INTEGRAL width per channel.
- BL_W, 14, BASELINE width per channel (ADC width plus 2 extra bits).
- AREA_BINS, 256, integration window length in clocks.
- PIPE_LAT, 4, extra clocks after the window before integral outputs are final.
- DEPTH_LOG2, 2, FIFO holds 2**DEPTH_LOG2 events.

Ports:
- CLK120  in  1  sole clock.
- RESET  in  1  synchronous reset, active-high.
- TRIGGERED  in  1  shower trigger, held high for the event.
- INTEGRAL_IN  in  NCHAN*AREA_W  channel c at bits [c*AREA_W +: AREA_W].
- PEAK_IN  in  NCHAN*ADC_W  per-channel peak.
- BASELINE_IN  in  NCHAN*BL_W  per-channel baseline.
- SATURATED_IN  in  NCHAN  per-channel saturation flag.
- EVT_ACK  in  1  pops the head event when EVT_VALID is high.
- EVT_VALID  out  1  FIFO not empty.
- EVT_INTEGRAL  out  NCHAN*AREA_W  head event integrals.
- EVT_PEAK  out  NCHAN*ADC_W  head event peaks.
- EVT_BASELINE  out  NCHAN*BL_W  head event baselines.
- EVT_SATURATED  out  NCHAN  head event saturation flags.
- EVT_TAG  out  8  head event sequence number.
- EVT_TIME  out  32  head event trigger timestamp (optional feature).
- FIFO_FULL  out  1  FIFO at capacity.
- OVF_CNT  out  8  events dropped, saturating.
- ABORT_CNT  out  8  triggers ended before capture, saturating.

Behaviour:
- Reset:
  - Synchronous; applies in any state, including mid-event.
  - All outputs go to 0, FIFO is emptied, state goes to IDLE, and the tag and window counters clear.
- States: IDLE, INTEG, CAPTURE, HOLDOFF.
- IDLE:
  - On a TRIGGERED rising edge (registered previous value 0, current 1), go to INTEG with WIN_CNT=0.
  - TRIGGERED already high when leaving reset does not start an event.
- INTEG:
  - WIN_CNT increments each clock.
  - If TRIGGERED goes low, return to IDLE and increment ABORT_CNT (saturating at 255). No FIFO write.
  - When WIN_CNT == AREA_BINS+PIPE_LAT-1, go to CAPTURE.
  - Capture therefore occurs AREA_BINS+PIPE_LAT clocks after the rising edge.
- CAPTURE, one cycle:
  - Samples all *_IN buses into a record tagged with TAG_CNT, then TAG_CNT increments with 8-bit wrap.
  - If the FIFO is full after any same-cycle pop, the record is dropped and OVF_CNT increments (saturating). TAG_CNT still increments, so gaps in the tag reveal drops.
  - Next state is HOLDOFF.
- HOLDOFF: wait for TRIGGERED == 0, then go to IDLE. A retrigger requires a fresh rising edge.
- FIFO:
  - First-word fall-through; EVT_* show the head record whenever EVT_VALID is high.
  - Pop occurs when EVT_ACK && EVT_VALID. EVT_ACK while empty is ignored.
  - Simultaneous pop and push when full: the pop takes effect first and the push succeeds, so there is no drop.
  - EVT_VALID and EVT_* update on the clock after a push into an empty FIFO (1-cycle latency).
  - EVT_* hold their value while not acked.
  - Pointers are DEPTH_LOG2+1 bits wide; full/empty are derived from the MSB compare.
- The block performs no arithmetic on captured data; values are stored bit-exact.

Optional Feature:
- Macro: SHWR_CAPTURE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running counter clears on RESET and wraps.
  - It is latched at the IDLE→INTEG transition and stored in the record.
  - EVT_TIME presents the head record's timestamp.
- Undefined: no counter and no storage; EVT_TIME is tied to 0.

Decomposition:
- Shared defines in sde_trigger_defs.vh: SHWR_CAPTURE_DEPTH_LOG2, SHWR_CAPTURE_PIPE_LAT, and record field offsets/width (SHWR_CAPTURE_REC_WIDTH).
- Sub-module shwr_capture_fifo: generic width/depth synchronous FIFO with the pop-before-push rule above.
- The FSM, counters and record packing stay in shwr_integral_capture.

Test Plan:
- Basic capture:
  - Stimulus: INTEGRAL_IN ch0=0x1234, PEAK_IN ch0=0x7FF, BASELINE_IN ch0=0x0C8; TRIGGERED high for 300 clocks.
  - Required: capture exactly 260 clocks after the rising edge; EVT_VALID next clock; EVT_TAG=0; fields exact.
- Abort:
  - Stimulus: TRIGGERED high for 100 clocks.
  - Required: no event, ABORT_CNT=1, state IDLE. The next full trigger yields EVT_TAG=0.
- Overflow:
  - Stimulus: 5 full triggers, no EVT_ACK.
  - Required: FIFO_FULL after the 4th, OVF_CNT=1, tags 0..3 retained. After acking all, the next event has EVT_TAG=5.
- Full with simultaneous pop:
  - Stimulus: FIFO full; EVT_ACK in the capture cycle.
  - Required: no drop, OVF_CNT unchanged, 4 events remain, head advances to the old 2nd record.
- Reset mid-window:
  - Stimulus: RESET at WIN_CNT=100 with 2 events queued.
  - Required: EVT_VALID=0, counters 0, IDLE. TRIGGERED still high produces no capture until a new rising edge.
- Timestamp (macro defined):
  - Stimulus: rising edge when the counter equals 1000.
  - Required: EVT_TIME=1000. With the macro undefined, EVT_TIME=0.
